mult8x8_seq_ctrl: RTL and testbench
===================================

// Module: mult8x8_seq_ctrl
// PURPOSE
//  Sequencer that time-multiplexes one 4x4 sub-multiplier to form an 8x8 product over up to 4 cycles.
//  Step order: AL*BL, AL*BH, AH*BL, AH*BH; partial products shifted by 0, 4, 4, 8 and accumulated.
//  Area-reduced alternative to the four-instance 8x8 array.
//  Sub-multiplier is external and purely combinational: sm_p = f(sm_a, sm_b) in the same cycle.
//  Upstream/downstream use valid/ready handshakes.
// PARAMETERS
//  SKIP_ZERO  0  1: skip any step whose A-nibble or B-nibble is 4'h0; 0: always run 4 steps
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operands a/b valid
//  in_ready   out  1   controller can accept; equals (state==IDLE)
//  a          in   8   multiplicand
//  b          in   8   multiplier
//  out_valid  out  1   r holds a finished product
//  out_ready  in   1   downstream accepts r
//  r          out  16  product
//  busy       out  1   state is a step state or DONE
//  sm_a       out  4   sub-multiplier operand A (nibble of latched a)
//  sm_b       out  4   sub-multiplier operand B (nibble of latched b)
//  sm_p       in   8   sub-multiplier product of sm_a, sm_b (combinational)
// BEHAVIOUR
//  Reset (rst=1 at an edge, any state): state=IDLE, acc/r=0, out_valid=0, busy=0, sm_a=sm_b=0, operand regs=0.
//  After reset, in_ready=1.
//  States: IDLE, S0 (AL*BL), S1 (AL*BH), S2 (AH*BL), S3 (AH*BH), DONE.
//  IDLE, in_valid=1: latch a/b, clear acc, go to the first required step (or DONE if none).
//  Step S_i, during the cycle: drive sm_a/sm_b with that step's nibbles.
//  Step S_i, at the edge: acc <= acc + (zero-extended sm_p << shift_i), 16-bit, no overflow possible.
//    Then go to the next required step, or DONE after the last.
//  Required steps: SKIP_ZERO=0 -> all 4; SKIP_ZERO=1 -> only steps with both nibbles nonzero (N = 0..4).
//  Timing: count the accept cycle as cycle 0. Steps occupy cycles 1..N.
//    out_valid=1 and r=acc from cycle N+1.
//  Outside step states: sm_a=sm_b=0.
//  DONE: out_valid and r hold stable while out_ready=0; in_ready=0, so in_valid is ignored.
//  DONE, out_ready=1: go to IDLE next cycle, out_valid drops.
//    No same-cycle re-accept; throughput is 1 op per N+2 cycles.
//  r keeps its last value in IDLE and is updated only on entering DONE.
//  Operand regs are unaffected by a/b changes after accept.
//  Reset mid-operation aborts the op; no out_valid is produced for it.
// CONFIGURATION
//  MULT_SEQ_OR_ACC_EN defined: accumulate with bitwise OR (acc <= acc | (sm_p << shift_i)).
//    Matches the OR-combine approximate 8x8 family.
//  Not defined: exact binary addition. With an exact sm_p, r == a*b.
//  Sequencing, latency and handshake are identical in both builds.
// TESTING
//  1. SKIP_ZERO=0, a=8'hFF, b=8'hFF, out_ready=1, exact sm_p model:
//     out_valid in cycle 5; r=16'hFE01 (OR build: 16'hEFF1).
//  2. a=8'h12, b=8'h34: sm_a/sm_b sequence 2/4, 2/3, 1/4, 1/3;
//     r=16'h03A8 (OR build: 16'h0368).
//  3. SKIP_ZERO=1, a=8'h50, b=8'h07: only step S2 runs (sm_a=5, sm_b=7);
//     out_valid in cycle 2; r=16'h0230.
//     Then a=8'h00, b=8'hAB: out_valid in cycle 1, r=0.
//  4. Backpressure: hold out_ready=0 for 3 cycles after out_valid.
//     r and out_valid stable, in_ready=0, an in_valid pulse is ignored.
//     After out_ready=1: IDLE next cycle.
//  5. Assert rst during S2: next cycle IDLE, out_valid=0, r=0, in_ready=1.
//     A following op a=8'h0F, b=8'h0F gives r=16'h00E1.
//  6. Random a/b over 1000 ops with random in_valid/out_ready gaps:
//     r matches the golden model (exact a*b, or the OR-combine model under MULT_SEQ_OR_ACC_EN).

Source files
------------

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 multiplier controller: drives one external 4x4 sub-multiplier over up to 4 steps.
// Define MULT_SEQ_OR_ACC_EN to combine partial products with bitwise OR instead of addition.
module mult8x8_seq_ctrl #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r,
  output logic        busy,
  output logic [3:0]  sm_a,
  output logic [3:0]  sm_b,
  input  logic [7:0]  sm_p
);

  typedef enum logic [2:0] {StIdle, StS0, StS1, StS2, StS3, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] acc_q, acc_d, r_q, r_d;
  logic [15:0] addend;
  logic        step_active;
  logic [3:0]  req_q;

  // Bit i set when step i must run: step order AL*BL, AL*BH, AH*BL, AH*BH.
  function automatic logic [3:0] req_steps(input logic [7:0] x, input logic [7:0] y);
    logic [3:0] nz;
    nz[0] = (|x[3:0]) & (|y[3:0]);
    nz[1] = (|x[3:0]) & (|y[7:4]);
    nz[2] = (|x[7:4]) & (|y[3:0]);
    nz[3] = (|x[7:4]) & (|y[7:4]);
    return SKIP_ZERO ? nz : 4'hF;
  endfunction

  function automatic state_e first_step(input logic [3:0] m);
    if (m[0])      return StS0;
    else if (m[1]) return StS1;
    else if (m[2]) return StS2;
    else if (m[3]) return StS3;
    else           return StDone;
  endfunction

  assign req_q = req_steps(a_q, b_q);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    r_d         = r_q;
    sm_a        = 4'h0;
    sm_b        = 4'h0;
    addend      = 16'h0;
    step_active = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 16'h0;
          state_d = first_step(req_steps(a, b));
        end
      end
      StS0: begin
        sm_a        = a_q[3:0];
        sm_b        = b_q[3:0];
        addend      = {8'h00, sm_p};
        step_active = 1'b1;
        state_d     = first_step(req_q & 4'b1110);
      end
      StS1: begin
        sm_a        = a_q[3:0];
        sm_b        = b_q[7:4];
        addend      = {4'h0, sm_p, 4'h0};
        step_active = 1'b1;
        state_d     = first_step(req_q & 4'b1100);
      end
      StS2: begin
        sm_a        = a_q[7:4];
        sm_b        = b_q[3:0];
        addend      = {4'h0, sm_p, 4'h0};
        step_active = 1'b1;
        state_d     = first_step(req_q & 4'b1000);
      end
      StS3: begin
        sm_a        = a_q[7:4];
        sm_b        = b_q[7:4];
        addend      = {sm_p, 8'h00};
        step_active = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (step_active) begin
`ifdef MULT_SEQ_OR_ACC_EN
      acc_d = acc_q | addend;
`else
      acc_d = acc_q + addend;
`endif
    end

    // r only changes on the transition into DONE, so it holds through IDLE.
    if (state_d == StDone && state_q != StDone) r_d = acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
      r_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign r         = r_q;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Bench for mult8x8_seq_ctrl: one instance without and one with zero-nibble skipping,
// each with an exact combinational 4x4 sub-multiplier.
module tb_mult8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a [2];
  logic [7:0]  b [2];
  logic [7:0]  sm_p [2];
  logic [3:0]  sm_a [2];
  logic [3:0]  sm_b [2];
  logic [15:0] r [2];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  seq_q[$];

  always #5 clk = ~clk;

  mult8x8_seq_ctrl #(.SKIP_ZERO(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .r(r[0]), .busy(busy[0]), .sm_a(sm_a[0]), .sm_b(sm_b[0]), .sm_p(sm_p[0])
  );

  mult8x8_seq_ctrl #(.SKIP_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .r(r[1]), .busy(busy[1]), .sm_a(sm_a[1]), .sm_b(sm_b[1]), .sm_p(sm_p[1])
  );

  assign sm_p[0] = {4'h0, sm_a[0]} * {4'h0, sm_b[0]};
  assign sm_p[1] = {4'h0, sm_b[1]} * {4'h0, sm_a[1]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    int al, ah, bl, bh;
    al = int'(x) % 16;
    ah = int'(x) / 16;
    bl = int'(y) % 16;
    bh = int'(y) / 16;
`ifdef MULT_SEQ_OR_ACC_EN
    return 16'((al * bl) | ((al * bh) * 16) | ((ah * bl) * 16) | ((ah * bh) * 256));
`else
    return 16'(int'(x) * int'(y));
`endif
  endfunction

  // One operation from an IDLE negedge; leaves the bench at a negedge with the DUT idle.
  task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input int hold, input string tag);
    logic [15:0] exp_r;
    logic [7:0]  exp_seq[$];
    int          nib_a[4];
    int          nib_b[4];
    int          lat;
    exp_r = model(av, bv);
    nib_a = '{int'(av) % 16, int'(av) % 16, int'(av) / 16, int'(av) / 16};
    nib_b = '{int'(bv) % 16, int'(bv) / 16, int'(bv) % 16, int'(bv) / 16};
    for (int j = 0; j < 4; j++)
      if (sel == 0 || (nib_a[j] != 0 && nib_b[j] != 0))
        exp_seq.push_back(8'(nib_a[j] * 16 + nib_b[j]));
    check({tag, ":in_ready_before"}, 32'(in_ready[sel]), 32'd1);
    a[sel] = av;
    b[sel] = bv;
    in_valid[sel] = 1'b1;
    out_ready[sel] = (hold == 0);
    seq_q.delete();
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      in_valid[sel] = 1'b0;
      a[sel] = 8'($urandom);
      b[sel] = 8'($urandom);
      if (out_valid[sel]) lat = c;
      else begin
        check({tag, ":busy_in_step"}, 32'(busy[sel]), 32'd1);
        seq_q.push_back({sm_a[sel], sm_b[sel]});
      end
    end
    if (lat == 0) begin
      check({tag, ":timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_seq.size() + 1));
    check({tag, ":r"}, 32'(r[sel]), 32'(exp_r));
    check({tag, ":steps"}, 32'(seq_q.size()), 32'(exp_seq.size()));
    for (int i = 0; i < seq_q.size() && i < exp_seq.size(); i++)
      check({tag, ":sm_ab"}, 32'(seq_q[i]), 32'(exp_seq[i]));
    for (int h = 0; h < hold; h++) begin
      check({tag, ":hold_valid"}, 32'(out_valid[sel]), 32'd1);
      check({tag, ":hold_r"}, 32'(r[sel]), 32'(exp_r));
      check({tag, ":hold_in_ready"}, 32'(in_ready[sel]), 32'd0);
      in_valid[sel] = (h == 1);
      @(negedge clk);
    end
    in_valid[sel] = 1'b0;
    out_ready[sel] = 1'b1;
    @(negedge clk);
    check({tag, ":idle_in_ready"}, 32'(in_ready[sel]), 32'd1);
    check({tag, ":idle_valid"}, 32'(out_valid[sel]), 32'd0);
    check({tag, ":idle_busy"}, 32'(busy[sel]), 32'd0);
    check({tag, ":idle_r"}, 32'(r[sel]), 32'(exp_r));
    out_ready[sel] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 2'b00;
    out_ready = 2'b00;
    a = '{8'h00, 8'h00};
    b = '{8'h00, 8'h00};
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset:in_ready", 32'(in_ready[s]), 32'd1);
      check("reset:out_valid", 32'(out_valid[s]), 32'd0);
      check("reset:busy", 32'(busy[s]), 32'd0);
      check("reset:r", 32'(r[s]), 32'd0);
      check("reset:sm", 32'({sm_a[s], sm_b[s]}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 8'hFF, 8'hFF, 0, "ff_ff");
`ifdef MULT_SEQ_OR_ACC_EN
    check("ff_ff:const", 32'(r[0]), 32'h0000EFF1);
`else
    check("ff_ff:const", 32'(r[0]), 32'h0000FE01);
`endif
    run_op(0, 8'h12, 8'h34, 0, "12_34");
`ifdef MULT_SEQ_OR_ACC_EN
    check("12_34:const", 32'(r[0]), 32'h00000368);
`else
    check("12_34:const", 32'(r[0]), 32'h000003A8);
`endif
    run_op(1, 8'h50, 8'h07, 0, "skip_50_07");
    check("skip_50_07:const", 32'(r[1]), 32'h00000230);
    run_op(1, 8'h00, 8'hAB, 0, "skip_00_ab");
    check("skip_00_ab:const", 32'(r[1]), 32'h00000000);

    run_op(0, 8'hA7, 8'h3C, 3, "backpressure");

    // Abort in S2 (cycle 3 of a four-step op).
    a[0] = 8'hFF;
    b[0] = 8'hFF;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
    end
    check("abort:sm_in_s2", 32'({sm_a[0], sm_b[0]}), 32'h000000FF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort:in_ready", 32'(in_ready[0]), 32'd1);
    check("abort:out_valid", 32'(out_valid[0]), 32'd0);
    check("abort:r", 32'(r[0]), 32'd0);
    check("abort:busy", 32'(busy[0]), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("abort:no_valid", 32'(out_valid[0]), 32'd0);
    end
    run_op(0, 8'h0F, 8'h0F, 0, "after_abort");
    check("after_abort:const", 32'(r[0]), 32'h000000E1);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra = ra & 8'hF0;
      if ($urandom_range(0, 3) == 0) rb = rb & 8'h0F;
      if ($urandom_range(0, 7) == 0) ra = ra & 8'h0F;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(i % 2, ra, rb, int'($urandom_range(0, 2)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
